// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with stall-captured redirect, return-address stack and sticky halt
module pc_unit #(
  parameter int ADDR_W     = 16,
  parameter int RESET_ADDR = 0,
  parameter int STEP       = 1,
  parameter int RAS_DEPTH  = 4,
  localparam int CNT_W     = $clog2(RAS_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              hlt,
  input  logic              redir_vld,
  input  logic [ADDR_W-1:0] redir_addr,
  input  logic              call,
  input  logic              ret,
  output logic [ADDR_W-1:0] iaddr,
  output logic [ADDR_W-1:0] pc_plus_1,
  output logic              halted,
  output logic              redir_pend,
  output logic [CNT_W-1:0]  ras_count,
  output logic              ras_underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  typedef enum logic {S_RUN, S_HALTED} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pend_addr;
  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  top_ptr;

  logic              active;
  logic              ras_nonempty;
  logic              do_push;
  logic              do_pop;
  logic [PTR_W-1:0]  ptr_inc;
  logic [PTR_W-1:0]  ptr_dec;
  logic [ADDR_W-1:0] ras_top;

  assign pc_plus_1 = iaddr + ADDR_W'(STEP);

  // RAS and PC only advance in a live, non-stalled, non-halting RUN cycle
  always_comb begin
    active       = (state == S_RUN) && !hlt && !stall;
    ras_nonempty = (ras_count != '0);
    do_push      = active && call;
    do_pop       = active && ret && ras_nonempty;
    ptr_inc      = (top_ptr == PTR_MAX) ? '0 : top_ptr + 1'b1;
    ptr_dec      = (top_ptr == '0) ? PTR_MAX : top_ptr - 1'b1;
    ras_top      = ras_mem[top_ptr];
  end

  // Simultaneous call+ret replaces the top in place; a lone push overwrites the oldest when full
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      ras_mem[do_pop ? top_ptr : ptr_inc] <= pc_plus_1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_RUN;
      iaddr         <= ADDR_W'(RESET_ADDR);
      halted        <= 1'b0;
      redir_pend    <= 1'b0;
      pend_addr     <= '0;
      ras_count     <= '0;
      top_ptr       <= '0;
      ras_underflow <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (hlt) begin
            state      <= S_HALTED;
            halted     <= 1'b1;
            redir_pend <= 1'b0;
          end else if (stall) begin
            if (redir_vld) begin
              pend_addr  <= redir_addr;
              redir_pend <= 1'b1;
            end
          end else begin
            redir_pend <= 1'b0;
            if (redir_vld)             iaddr <= redir_addr;
            else if (redir_pend)       iaddr <= pend_addr;
            else if (ret && ras_nonempty) iaddr <= ras_top;
            else                       iaddr <= pc_plus_1;

            if (ret && !ras_nonempty) ras_underflow <= 1'b1;

            if (do_push && !do_pop) begin
              top_ptr <= ptr_inc;
              if (ras_count != CNT_MAX) ras_count <= ras_count + 1'b1;
            end else if (do_pop && !do_push) begin
              top_ptr   <= ptr_dec;
              ras_count <= ras_count - 1'b1;
            end
          end
        end
        default: begin
          state <= S_HALTED;
        end
      endcase
    end
  end

endmodule
